thread_fetch_scheduler: RTL and testbench

THREAD_FETCH_SCHEDULER -- requirements
Module: thread_fetch_scheduler

---
 rtl/thread_fetch_scheduler_pkg.sv | 8 +
 rtl/thread_fetch_scheduler_picker.sv | 24 ++
 rtl/thread_fetch_scheduler.sv | 81 ++++++++
 tb/tb_thread_fetch_scheduler.sv | 119 +++++++++++
 4 files changed

// File: rtl/thread_fetch_scheduler_pkg.sv
// thread_fetch_scheduler_pkg: default widths shared by the scheduler, pc_array users and the processor top.
package thread_fetch_scheduler_pkg;
  localparam int THREAD_INDEX_BITS_DEF = 3;
  localparam int PC_WIDTH_DEF = 8;
  function automatic int num_threads(input int bits);
    return 2 ** bits;
  endfunction
endpackage

// File: rtl/thread_fetch_scheduler_picker.sv
// rr_thread_picker: first set mask bit at or after rr_ptr, wrapping modulo 2**W.
module rr_thread_picker #(
  parameter int W = 3
) (
  input  logic [2**W-1:0] mask,
  input  logic [W-1:0]    rr_ptr,
  output logic            found,
  output logic [W-1:0]    index
);
  logic [W-1:0] idx;
  // Scan farthest offset first so the nearest running thread is the last to win.
  always_comb begin
    found = 1'b0;
    index = '0;
    idx = '0;
    for (int k = 2**W - 1; k >= 0; k--) begin
      idx = rr_ptr + W'(k);
      if (mask[idx]) begin
        found = 1'b1;
        index = idx;
      end
    end
  end
endmodule

// File: rtl/thread_fetch_scheduler.sv
// thread_fetch_scheduler: round-robin fetch issue across hardware threads with start/halt/redirect control.
module thread_fetch_scheduler
  import thread_fetch_scheduler_pkg::*;
#(
  parameter int                              THREAD_INDEX_BITS  = THREAD_INDEX_BITS_DEF,
  parameter int                              PC_WIDTH           = PC_WIDTH_DEF,
  parameter logic [PC_WIDTH-1:0]             RESET_PC           = '0,
  parameter logic [2**THREAD_INDEX_BITS-1:0] RESET_RUNNING_MASK = '1
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  in_stall,
  input  logic                                  in_start_valid,
  input  logic [THREAD_INDEX_BITS-1:0]          in_start_thread_index,
  input  logic [PC_WIDTH-1:0]                   in_start_pc,
  input  logic                                  in_halt_valid,
  input  logic [THREAD_INDEX_BITS-1:0]          in_halt_thread_index,
  input  logic                                  in_redirect_valid,
  input  logic [THREAD_INDEX_BITS-1:0]          in_redirect_thread_index,
  input  logic [PC_WIDTH-1:0]                   in_redirect_pc,
  output logic                                  out_fetch_valid,
  output logic [THREAD_INDEX_BITS-1:0]          out_thread_index,
  output logic [PC_WIDTH-1:0]                   out_program_counter,
  output logic [THREAD_INDEX_BITS+PC_WIDTH-1:0] out_fetch_addr,
  output logic [2**THREAD_INDEX_BITS-1:0]       out_running_mask
);
  localparam int NUM_THREADS = num_threads(THREAD_INDEX_BITS);
  logic [PC_WIDTH-1:0]          pc_q [NUM_THREADS];
  logic [PC_WIDTH-1:0]          pc_d [NUM_THREADS];
  logic [NUM_THREADS-1:0]       run_q, run_d;
  logic [THREAD_INDEX_BITS-1:0] rr_q, rr_d, tid_q, tid_d, sel;
  logic [PC_WIDTH-1:0]          opc_q, opc_d;
  logic                         valid_q, valid_d, found, issue;
  rr_thread_picker #(.W(THREAD_INDEX_BITS)) u_pick (
    .mask(run_q),
    .rr_ptr(rr_q),
    .found(found),
    .index(sel)
  );
  assign issue = !in_stall && found;
  // Priority per thread, lowest to highest: increment, redirect, start; halt beats start.
  always_comb begin
    pc_d = pc_q;
    run_d = run_q;
    for (int t = 0; t < NUM_THREADS; t++) begin
      if (issue && sel == THREAD_INDEX_BITS'(t)) pc_d[t] = pc_q[t] + 1'b1;
      if (in_redirect_valid && in_redirect_thread_index == THREAD_INDEX_BITS'(t)) pc_d[t] = in_redirect_pc;
      if (in_halt_valid && in_halt_thread_index == THREAD_INDEX_BITS'(t)) run_d[t] = 1'b0;
      else if (in_start_valid && in_start_thread_index == THREAD_INDEX_BITS'(t)) begin
        run_d[t] = 1'b1;
        pc_d[t] = in_start_pc;
      end
    end
    valid_d = in_stall ? valid_q : found;
    tid_d = issue ? sel : tid_q;
    opc_d = issue ? pc_q[sel] : opc_q;
    rr_d = issue ? sel + 1'b1 : rr_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int t = 0; t < NUM_THREADS; t++) pc_q[t] <= RESET_PC;
      run_q <= RESET_RUNNING_MASK;
      rr_q <= '0;
      valid_q <= 1'b0;
      tid_q <= '0;
      opc_q <= '0;
    end else begin
      pc_q <= pc_d;
      run_q <= run_d;
      rr_q <= rr_d;
      valid_q <= valid_d;
      tid_q <= tid_d;
      opc_q <= opc_d;
    end
  end
  assign out_fetch_valid = valid_q;
  assign out_thread_index = tid_q;
  assign out_program_counter = opc_q;
  assign out_fetch_addr = {tid_q, opc_q};
  assign out_running_mask = run_q;
endmodule

// File: tb/tb_thread_fetch_scheduler.sv
// tb_thread_fetch_scheduler: directed vector table plus reset sequences for the fetch scheduler.
module tb_thread_fetch_scheduler;
  typedef struct {
    bit st; bit sv; bit [2:0] si; bit [7:0] sp;
    bit hv; bit [2:0] hi;
    bit rv; bit [2:0] ri; bit [7:0] rp;
    bit ev; bit [2:0] et; bit [7:0] ep; bit [7:0] em;
  } vec_t;
  logic clk = 0, reset = 1, in_stall = 0;
  logic in_start_valid = 0, in_halt_valid = 0, in_redirect_valid = 0;
  logic [2:0] in_start_thread_index = 0, in_halt_thread_index = 0, in_redirect_thread_index = 0;
  logic [7:0] in_start_pc = 0, in_redirect_pc = 0;
  logic out_fetch_valid;
  logic [2:0] out_thread_index;
  logic [7:0] out_program_counter;
  logic [10:0] out_fetch_addr;
  logic [7:0] out_running_mask;
  int errors = 0, checks = 0;
  vec_t tbl[$];
  thread_fetch_scheduler dut (
    .clk(clk), .reset(reset), .in_stall(in_stall),
    .in_start_valid(in_start_valid), .in_start_thread_index(in_start_thread_index), .in_start_pc(in_start_pc),
    .in_halt_valid(in_halt_valid), .in_halt_thread_index(in_halt_thread_index),
    .in_redirect_valid(in_redirect_valid), .in_redirect_thread_index(in_redirect_thread_index),
    .in_redirect_pc(in_redirect_pc),
    .out_fetch_valid(out_fetch_valid), .out_thread_index(out_thread_index),
    .out_program_counter(out_program_counter), .out_fetch_addr(out_fetch_addr),
    .out_running_mask(out_running_mask)
  );
  always #5 clk = ~clk;
  function automatic vec_t mk(bit st, bit sv, bit [2:0] si, bit [7:0] sp, bit hv, bit [2:0] hi,
                              bit rv, bit [2:0] ri, bit [7:0] rp, bit ev, bit [2:0] et, bit [7:0] ep, bit [7:0] em);
    vec_t v;
    v.st = st; v.sv = sv; v.si = si; v.sp = sp; v.hv = hv; v.hi = hi;
    v.rv = rv; v.ri = ri; v.rp = rp; v.ev = ev; v.et = et; v.ep = ep; v.em = em;
    return v;
  endfunction
  function automatic vec_t iss(bit [2:0] et, bit [7:0] ep, bit [7:0] em);
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, et, ep, em);
  endfunction
  task automatic chk(string name, int n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0d: got %0h expected %0h", name, n, act, exp);
    end
  endtask
  task automatic chk_out(int n, bit ev, bit [2:0] et, bit [7:0] ep, bit [7:0] em);
    chk("valid", n, 32'(out_fetch_valid), 32'(ev));
    chk("thread", n, 32'(out_thread_index), 32'(et));
    chk("pc", n, 32'(out_program_counter), 32'(ep));
    chk("addr", n, 32'(out_fetch_addr), 32'({et, ep}));
    chk("mask", n, 32'(out_running_mask), 32'(em));
  endtask
  initial begin
    for (int i = 0; i < 8; i++) tbl.push_back(iss(3'(i), 8'h00, 8'hFF));
    tbl.push_back(iss(0, 8'h01, 8'hFF));
    tbl.push_back(iss(1, 8'h01, 8'hFF));
    tbl.push_back(mk(1, 0, 0, 0, 1, 2, 0, 0, 0, 1, 1, 8'h01, 8'hFB));
    tbl.push_back(mk(1, 0, 0, 0, 1, 3, 0, 0, 0, 1, 1, 8'h01, 8'hF3));
    tbl.push_back(iss(4, 8'h01, 8'hF3)); tbl.push_back(iss(5, 8'h01, 8'hF3));
    tbl.push_back(iss(6, 8'h01, 8'hF3)); tbl.push_back(iss(7, 8'h01, 8'hF3));
    tbl.push_back(iss(0, 8'h02, 8'hF3)); tbl.push_back(iss(1, 8'h02, 8'hF3));
    tbl.push_back(iss(4, 8'h02, 8'hF3)); tbl.push_back(iss(5, 8'h02, 8'hF3));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 8'h02, 8'hF3));
    tbl.push_back(iss(6, 8'h02, 8'hF3)); tbl.push_back(iss(7, 8'h02, 8'hF3));
    tbl.push_back(iss(0, 8'h03, 8'hF3));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 8'h40, 1, 1, 8'h03, 8'hF3));
    tbl.push_back(iss(4, 8'h03, 8'hF3)); tbl.push_back(iss(5, 8'h03, 8'hF3));
    tbl.push_back(iss(6, 8'h03, 8'hF3)); tbl.push_back(iss(7, 8'h03, 8'hF3));
    tbl.push_back(iss(0, 8'h04, 8'hF3)); tbl.push_back(iss(1, 8'h40, 8'hF3));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 4, 8'hFF, 1, 1, 8'h40, 8'hF3));
    tbl.push_back(iss(4, 8'hFF, 8'hF3));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 2, 8'h20, 1, 5, 8'h04, 8'hF3));
    tbl.push_back(iss(6, 8'h04, 8'hF3)); tbl.push_back(iss(7, 8'h04, 8'hF3));
    tbl.push_back(iss(0, 8'h05, 8'hF3)); tbl.push_back(iss(1, 8'h41, 8'hF3));
    tbl.push_back(iss(4, 8'h00, 8'hF3));
    tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 1, 4, 8'h00, 8'hF2));
    tbl.push_back(mk(1, 0, 0, 0, 1, 1, 0, 0, 0, 1, 4, 8'h00, 8'hF0));
    tbl.push_back(mk(1, 0, 0, 0, 1, 4, 0, 0, 0, 1, 4, 8'h00, 8'hE0));
    tbl.push_back(mk(1, 0, 0, 0, 1, 5, 0, 0, 0, 1, 4, 8'h00, 8'hC0));
    tbl.push_back(mk(1, 0, 0, 0, 1, 6, 0, 0, 0, 1, 4, 8'h00, 8'h80));
    tbl.push_back(mk(1, 0, 0, 0, 1, 7, 0, 0, 0, 1, 4, 8'h00, 8'h00));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 8'h00, 8'h00));
    tbl.push_back(mk(0, 1, 6, 8'h10, 1, 6, 0, 0, 0, 0, 4, 8'h00, 8'h00));
    tbl.push_back(mk(0, 1, 6, 8'h10, 0, 0, 0, 0, 0, 0, 4, 8'h00, 8'h40));
    tbl.push_back(iss(6, 8'h10, 8'h40)); tbl.push_back(iss(6, 8'h11, 8'h40));
    tbl.push_back(mk(0, 1, 3, 8'h30, 1, 6, 1, 2, 8'h55, 1, 6, 8'h12, 8'h08));
    tbl.push_back(iss(3, 8'h30, 8'h08)); tbl.push_back(iss(3, 8'h31, 8'h08));
    tbl.push_back(mk(0, 1, 2, 8'h60, 0, 0, 1, 2, 8'h70, 1, 3, 8'h32, 8'h0C));
    tbl.push_back(iss(2, 8'h60, 8'h0C));
    // Reset with control inputs active: they must be ignored.
    reset = 1; in_halt_valid = 1; in_halt_thread_index = 0;
    in_start_valid = 1; in_start_thread_index = 1; in_start_pc = 8'h99;
    repeat (2) @(posedge clk);
    #1 chk_out(-1, 0, 0, 8'h00, 8'hFF);
    reset = 0; in_halt_valid = 0; in_start_valid = 0;
    foreach (tbl[n]) begin
      in_stall = tbl[n].st;
      in_start_valid = tbl[n].sv; in_start_thread_index = tbl[n].si; in_start_pc = tbl[n].sp;
      in_halt_valid = tbl[n].hv; in_halt_thread_index = tbl[n].hi;
      in_redirect_valid = tbl[n].rv; in_redirect_thread_index = tbl[n].ri; in_redirect_pc = tbl[n].rp;
      @(posedge clk);
      #1 chk_out(n, tbl[n].ev, tbl[n].et, tbl[n].ep, tbl[n].em);
    end
    // Mid-operation reset while stalled.
    in_start_valid = 0; in_halt_valid = 0; in_redirect_valid = 0;
    reset = 1; in_stall = 1; in_halt_valid = 1; in_halt_thread_index = 0;
    @(posedge clk);
    #1 chk_out(100, 0, 0, 8'h00, 8'hFF);
    reset = 0; in_stall = 0; in_halt_valid = 0;
    @(posedge clk);
    #1 chk_out(101, 1, 0, 8'h00, 8'hFF);
    @(posedge clk);
    #1 chk_out(102, 1, 1, 8'h00, 8'hFF);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
